// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one recoded multiplier group per RUN cycle.
// Optional early termination is enabled by defining BOOTH_EARLY_TERM_EN.
module booth_seq_multiplier #(
  parameter int unsigned N_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     multiplicand,
  input  logic [N_BITS-1:0]     multiplier,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_BITS-1:0]   product,
  output logic                  busy
);

  localparam int unsigned ProdW   = 2 * N_BITS;
  localparam int unsigned NGroups = N_BITS / 2;
  localparam int unsigned GW      = $clog2(NGroups);
  localparam int unsigned ShW     = $clog2(N_BITS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   a_q, a_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic [ProdW-1:0]    acc_q, acc_d;
  logic [GW-1:0]       g_q, g_d;

  logic [ShW-1:0]      shamt;
  logic [N_BITS:0]     b_ext;
  logic [2:0]          booth_group;
  logic [ProdW-1:0]    a_ext;
  logic [ProdW-1:0]    pp;
  logic                last_group;
  logic                early_done;

  assign shamt       = ShW'({g_q, 1'b0});
  // Appending a zero below the LSB supplies B[-1] = 0 for group 0.
  assign b_ext       = {b_q, 1'b0};
  assign booth_group = b_ext[shamt +: 3];
  assign a_ext       = {{N_BITS{a_q[N_BITS-1]}}, a_q};
  assign last_group  = (g_q == GW'(NGroups - 1));

`ifdef BOOTH_EARLY_TERM_EN
  // Once B[31:2g+1] is all-equal every remaining Booth group decodes to zero.
  logic [N_BITS-1:0] b_hi;
  assign b_hi       = $signed(b_q) >>> (shamt + 1'b1);
  assign early_done = (b_hi == '0) || (&b_hi);
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    pp = '0;
    unique case (booth_group)
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    g_d     = g_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          acc_d   = '0;
          g_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + (pp << shamt);
        g_d   = g_q + 1'b1;
        if (last_group || early_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      g_q     <= g_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign product   = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier with a queue scoreboard of expected products.
module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  booth_seq_multiplier #(.N_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Number of RUN cycles expected for multiplier b.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    for (int g = 0; g < 16; g++) begin
      logic same;
      same = 1'b1;
      for (int k = 2 * g + 1; k < 32; k++) begin
        if (b[k] != b[31]) same = 1'b0;
      end
      if (same) return g + 1;
    end
    return 16;
`else
    return 16;
`endif
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int          cnt;
    logic [63:0] exp;
    logic [63:0] held;
    longint      pa;
    longint      pb;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ready_before_accept", 64'(in_ready), 64'd1);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    @(posedge clk); #1;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    exp_q.push_back(pa * pb);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("in_ready_in_run", 64'(in_ready), 64'd0);
    // Junk operands with in_valid still high must be ignored while busy.
    multiplicand = $urandom;
    multiplier   = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", 64'(cnt), 64'(exp_lat(b)));
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("product", product, exp);
    end else begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed empty queue, required one entry");
    end
    held = product;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_product_stable", product, held);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("idle_product_zero", product, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;

    run_op(32'd3, 32'd5, 0);
    run_op(-32'sd7, 32'd6, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 5);
    run_op(32'h8000_0000, 32'd1, 0);
    run_op(32'd9, 32'd1, 0);
    run_op(32'd9, 32'hFFFF_FFFF, 0);
    run_op(32'h1234_5678, 32'd0, 0);
    run_op(32'd0, 32'hDEAD_BEEF, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op(32'h0000_ABCD, 32'h0007_0000, 0);
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, 0);
    end

    // Reset in the middle of RUN, at group 7.
    multiplicand = 32'd5;
    multiplier   = 32'h1234_5678;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_product", product, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    run_op(32'd2, 32'd2, 0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 SHALL have parameter N_BITS, default 32, operand width; only 32 is supported, giving 16 radix-4 groups and a 64-bit product.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port multiplicand, input, N_BITS, signed two's-complement operand A.
REQ-007 SHALL have port multiplier, input, N_BITS, signed two's-complement operand B (Booth-recoded).
REQ-008 SHALL have port out_valid, output, 1, product available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes product.
REQ-010 SHALL have port product, output, 64, signed A*B.
REQ-011 SHALL have port busy, output, 1, high in RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL hold in_ready=1 only in IDLE; an accept is in_valid&in_ready at a clock edge.
REQ-014 On accept, SHALL latch both operands, clear the 64-bit accumulator, set group counter g=0, and go to RUN.
REQ-015 In RUN, each cycle SHALL form booth_group = {B[2g+1], B[2g], B[2g-1]}, with B[-1]=0.
REQ-016 SHALL select the partial product from booth_group, sign-extended to 64 bits:
- 000/111: 0
- 001/010: +A
- 011: +2A
- 100: -2A
- 101/110: -A
REQ-017 SHALL shift the selected partial product left by 2g and add it to the accumulator, modulo 2^64.
REQ-018 After g=15 is accumulated, SHALL go to DONE, assert out_valid, and drive product = accumulator.
REQ-019 Latency without early termination: out_valid SHALL first be high 17 edges after the accept edge (16 RUN cycles).
REQ-020 SHALL keep product and out_valid stable in DONE while out_ready=0.
REQ-021 On out_valid&out_ready, SHALL return to IDLE with out_valid=0 next cycle; in_ready rises next cycle, with no same-cycle re-accept.
REQ-022 SHALL ignore in_valid and input operand changes during RUN and DONE.
REQ-023 SHALL produce exact results for all corner operands, including A=B=-2^31 (product 2^62) and A=-2^31, B=1.
REQ-024 SHALL hold product at 0 while in IDLE.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE from any state, including mid-RUN or DONE, discarding the in-flight operation.
REQ-026 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, g=0.
REQ-027 rst SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-028 Macro BOOTH_EARLY_TERM_EN SHALL control early termination.
REQ-029 With BOOTH_EARLY_TERM_EN defined, in RUN after accumulating group g: if B[31:2g+1] are all equal, SHALL go to DONE next edge. The remaining groups are all zero.
REQ-030 With BOOTH_EARLY_TERM_EN defined, B=0 SHALL reach DONE after 1 RUN cycle, and B=-1 after 1 RUN cycle.
REQ-031 Without BOOTH_EARLY_TERM_EN, SHALL always run exactly 16 RUN cycles.
REQ-032 The product value SHALL be identical with and without BOOTH_EARLY_TERM_EN; only latency differs.

Verification
REQ-033 A=3, B=5, out_ready=1 -> product=15; out_valid 17 edges after accept without macro.
REQ-034 A=-7, B=6 -> product=64'hFFFF_FFFF_FFFF_FFD6 (-42).
REQ-035 A=B=32'h8000_0000 -> product=64'h4000_0000_0000_0000; A=32'h7FFF_FFFF, B=32'h8000_0000 -> 64'hC000_0000_8000_0000.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> product/out_valid stable, in_ready=0; on release, in_ready=1 next cycle.
REQ-037 rst pulse at g=7 mid-RUN -> next cycle in_ready=1, out_valid=0, product=0; a following A=2, B=2 -> 4.
REQ-038 With BOOTH_EARLY_TERM_EN, A=9, B=1 -> product=9, out_valid 2 edges after accept; B=-1 -> -9, same latency.
